// File: rtl/microwave_timer_ctrl_pkg.sv
// microwave_timer_ctrl_pkg: shared state encoding, BCD digit type and default constants.
package microwave_timer_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int QUICK_SECS_TENS_DEF = 3;
    localparam int ALARM_TICKS_DEF     = 3;
endpackage

// File: rtl/microwave_timer_ctrl_bcd_time_dec.sv
// bcd_time_dec: combinational m:ss BCD decrement; zero flags a 0:00 result.
module bcd_time_dec
    import microwave_timer_ctrl_pkg::*;
(
    input  logic [3:0] min,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    output logic [3:0] min_d,
    output logic [3:0] tens_d,
    output logic [3:0] ones_d,
    output logic       zero
);
    logic ones_borrow, tens_borrow;

    always_comb begin
        ones_borrow = sec_ones == 4'd0;
        tens_borrow = ones_borrow && sec_tens == 4'd0;
        ones_d      = ones_borrow ? 4'd9 : sec_ones - 4'd1;
        // tens above 5 (typed 0:90) simply count down; only 0 wraps to 5
        tens_d      = !ones_borrow ? sec_tens : tens_borrow ? 4'd5 : sec_tens - 4'd1;
        min_d       = tens_borrow ? min - 4'd1 : min;
        zero        = {min_d, tens_d, ones_d} == 12'd0;
    end
endmodule

// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl: keypad entry, BCD countdown and magnetron control FSM.
// Define DONE_ALARM_EN to hold the alarm in DONE for ALARM_TICKS seconds.
module microwave_timer_ctrl
    import microwave_timer_ctrl_pkg::*;
#(
`ifdef DONE_ALARM_EN
    parameter int ALARM_TICKS     = ALARM_TICKS_DEF,
`endif
    parameter int QUICK_SECS_TENS = QUICK_SECS_TENS_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sec_tick,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_open,
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mag_on,
    output logic       alarm,
    output logic [2:0] state_o
);
    localparam bcd_t QUICK_TENS = bcd_t'(QUICK_SECS_TENS);

    state_t state, state_n;
    bcd_t   min_n, tens_n, ones_n, min_d, tens_d, ones_d;
    logic   dec_zero, go, digit_ok, time_zero;

    bcd_time_dec u_dec (
        .min      (min),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .min_d    (min_d),
        .tens_d   (tens_d),
        .ones_d   (ones_d),
        .zero     (dec_zero)
    );

    assign go        = start && !door_open;
    assign digit_ok  = digit_valid && digit <= 4'd9;
    assign time_zero = {min, sec_tens, sec_ones} == 12'd0;
    assign state_o   = state;

`ifdef DONE_ALARM_EN
    localparam int CW = $clog2(ALARM_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(ALARM_TICKS - 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt   <= '0;
            alarm <= 1'b0;
        end else begin
            // the tick that expires COOK must not count toward the alarm
            cnt   <= (state == DONE && state_n == DONE) ? cnt + CW'(sec_tick) : '0;
            alarm <= state_n == DONE;
        end
    end
`else
    assign alarm = 1'b0;
`endif

    always_comb begin
        state_n = state;
        min_n   = min;
        tens_n  = sec_tens;
        ones_n  = sec_ones;
        case (state)
            IDLE, SET: begin
                if (stop_clear) begin
                    state_n                 = IDLE;
                    {min_n, tens_n, ones_n} = '0;
                end else if (go && state == IDLE) begin
                    state_n                 = COOK;
                    {min_n, tens_n, ones_n} = {4'd0, QUICK_TENS, 4'd0};
                end else if (go) begin
                    state_n = time_zero ? IDLE : COOK;
                end else if (digit_ok) begin
                    state_n                 = SET;
                    {min_n, tens_n, ones_n} = {sec_tens, sec_ones, digit};
                end
            end
            COOK: begin
                if (stop_clear || door_open) begin
                    state_n = PAUSE;
                end else if (sec_tick) begin
                    state_n                 = dec_zero ? DONE : COOK;
                    {min_n, tens_n, ones_n} = {min_d, tens_d, ones_d};
                end
            end
            PAUSE: begin
                if (stop_clear) begin
                    state_n                 = IDLE;
                    {min_n, tens_n, ones_n} = '0;
                end else if (go) begin
                    state_n = COOK;
                end
            end
`ifdef DONE_ALARM_EN
            DONE: state_n = (stop_clear || door_open || (sec_tick && cnt == LAST)) ? IDLE : DONE;
`endif
            default: begin
                state_n                 = IDLE;
                {min_n, tens_n, ones_n} = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            min      <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            mag_on   <= 1'b0;
        end else begin
            state    <= state_n;
            min      <= min_n;
            sec_tens <= tens_n;
            sec_ones <= ones_n;
            mag_on   <= state_n == COOK;
        end
    end
endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// tb_microwave_timer_ctrl: self-checking bench; time is modelled as the decimal number m*100+tens*10+ones.
module tb_microwave_timer_ctrl;
    import microwave_timer_ctrl_pkg::*;

    localparam int QUICK   = 3;
    localparam int ALARM_N = 3;
`ifdef DONE_ALARM_EN
    localparam logic AL_ON = 1'b1;
`else
    localparam logic AL_ON = 1'b0;
`endif

    logic       clk = 1'b0, reset_n = 1'b0;
    logic       sec_tick = 1'b0, digit_valid = 1'b0, start = 1'b0, stop_clear = 1'b0, door_open = 1'b0;
    logic [3:0] digit = 4'd0;
    logic [3:0] min, sec_tens, sec_ones;
    logic       mag_on, alarm;
    logic [2:0] state_o;

    int     checks = 0, errors = 0;
    state_t m_st = IDLE;
    int     m_v = 0, m_ac = 0;
    bit     started = 1'b0;

    always #5 clk = ~clk;

    microwave_timer_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sec_tick    (sec_tick),
        .digit_valid (digit_valid),
        .digit       (digit),
        .start       (start),
        .stop_clear  (stop_clear),
        .door_open   (door_open),
        .min         (min),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .mag_on      (mag_on),
        .alarm       (alarm),
        .state_o     (state_o)
    );

    always @(posedge clk) begin : model
        state_t ns;
        int nv, nac;
        ns  = m_st;
        nv  = m_v;
        nac = 0;
        if (!reset_n) begin
            ns = IDLE;
            nv = 0;
        end else if (m_st == DONE) begin
`ifdef DONE_ALARM_EN
            nac = m_ac + (sec_tick ? 1 : 0);
            if (stop_clear || door_open || nac == ALARM_N) ns = IDLE;
`else
            ns = IDLE;
`endif
        end else if (stop_clear) begin
            ns = (m_st == COOK) ? PAUSE : IDLE;
            if (m_st != COOK) nv = 0;
        end else if (door_open && m_st == COOK) begin
            ns = PAUSE;
        end else if (start && !door_open && m_st != COOK) begin
            if (m_st == IDLE) begin
                nv = QUICK * 10;
                ns = COOK;
            end else begin
                ns = (m_st == SET && m_v == 0) ? IDLE : COOK;
            end
        end else if (sec_tick && m_st == COOK) begin
            nv = (m_v % 100 == 0) ? m_v - 41 : m_v - 1;
            if (nv == 0) ns = DONE;
        end else if (digit_valid && digit <= 4'd9 && (m_st == IDLE || m_st == SET)) begin
            nv = (m_v % 100) * 10 + int'(digit);
            ns = SET;
        end
        if (ns != DONE) nac = 0;
        m_st    <= ns;
        m_v     <= nv;
        m_ac    <= nac;
        started <= 1'b1;
    end

    always @(negedge clk) begin : compare
        logic exp_al;
        if (started) begin
            exp_al = AL_ON && (m_st == DONE);
            checks++;
            if (state_o !== m_st || min !== 4'(m_v / 100) || sec_tens !== 4'((m_v / 10) % 10) ||
                sec_ones !== 4'(m_v % 10) || mag_on !== (m_st == COOK) || alarm !== exp_al) begin
                errors++;
                $display("FAIL model @%0t: got st=%0d %0d:%0d%0d mag=%0b al=%0b, want st=%0d time=%0d mag=%0b al=%0b",
                         $time, state_o, min, sec_tens, sec_ones, mag_on, alarm, m_st, m_v, m_st == COOK, exp_al);
            end
        end
    end

    task automatic chk(input string nm, input state_t es, input int em, input int et, input int eo,
                       input logic emag, input logic eal);
        checks++;
        if (state_o !== es || min !== 4'(em) || sec_tens !== 4'(et) || sec_ones !== 4'(eo) ||
            mag_on !== emag || alarm !== eal) begin
            errors++;
            $display("FAIL %s: got st=%0d %0d:%0d%0d mag=%0b al=%0b, want st=%0d %0d:%0d%0d mag=%0b al=%0b",
                     nm, state_o, min, sec_tens, sec_ones, mag_on, alarm, es, em, et, eo, emag, eal);
        end
    endtask

    task automatic drive(input logic sc, input logic st, input logic tk, input logic dv, input logic [3:0] d);
        @(negedge clk);
        stop_clear  = sc;
        start       = st;
        sec_tick    = tk;
        digit_valid = dv;
        digit       = d;
        @(posedge clk);
        #1;
        stop_clear  = 1'b0;
        start       = 1'b0;
        sec_tick    = 1'b0;
        digit_valid = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);   drive(0, 0, 0, 1, d);    endtask
    task automatic tick_();                     drive(0, 0, 1, 0, 4'd0); endtask
    task automatic stop();                      drive(1, 0, 0, 0, 4'd0); endtask
    task automatic press_start();               drive(0, 1, 0, 0, 4'd0); endtask
    task automatic idle();                      drive(0, 0, 0, 0, 4'd0); endtask

    initial begin
        repeat (2) idle();
        chk("reset", IDLE, 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        key(4'd1); key(4'd3); key(4'd0);
        chk("keys_130", SET, 1, 3, 0, 0, 0);
        press_start();
        chk("start_130", COOK, 1, 3, 0, 1, 0);
        repeat (89) tick_();
        chk("cook_0_01", COOK, 0, 0, 1, 1, 0);
        tick_();
        chk("expire", DONE, 0, 0, 0, 0, AL_ON);
`ifdef DONE_ALARM_EN
        idle(); tick_(); tick_();
        chk("alarm_hold", DONE, 0, 0, 0, 0, 1);
        tick_();
        chk("alarm_end", IDLE, 0, 0, 0, 0, 0);
`else
        idle();
        chk("done_1clk", IDLE, 0, 0, 0, 0, 0);
`endif

        key(4'd1); key(4'd0); key(4'd0); press_start(); tick_();
        chk("1_00_tick", COOK, 0, 5, 9, 1, 0);
        stop(); stop();
        chk("cleared", IDLE, 0, 0, 0, 0, 0);
        key(4'd1); key(4'd0); press_start(); tick_();
        chk("0_10_tick", COOK, 0, 0, 9, 1, 0);
        stop(); stop();

        key(4'd4); key(4'd5); press_start();
        door_open = 1'b1;
        tick_();
        chk("door_tick", PAUSE, 0, 4, 5, 0, 0);
        press_start();
        chk("start_door_open", PAUSE, 0, 4, 5, 0, 0);
        door_open = 1'b0;
        press_start();
        chk("resume", COOK, 0, 4, 5, 1, 0);
        key(4'd7);
        chk("digit_in_cook", COOK, 0, 4, 5, 1, 0);
        tick_();
        chk("resume_tick", COOK, 0, 4, 4, 1, 0);
        door_open = 1'b1;
        drive(1, 1, 1, 1, 4'd3);
        chk("all_keys_cook", PAUSE, 0, 4, 4, 0, 0);
        door_open = 1'b0;
        stop();

        press_start();
        chk("quick", COOK, 0, QUICK, 0, 1, 0);
        stop();
        chk("quick_pause", PAUSE, 0, QUICK, 0, 0, 0);
        stop();
        chk("quick_clear", IDLE, 0, 0, 0, 0, 0);

        key(4'hC);
        chk("digit_C", IDLE, 0, 0, 0, 0, 0);
        key(4'd9); key(4'hF);
        chk("digit_F", SET, 0, 0, 9, 0, 0);
        door_open = 1'b1;
        press_start();
        chk("set_door_start", SET, 0, 0, 9, 0, 0);
        door_open = 1'b0;
        drive(0, 1, 0, 1, 4'd5);
        chk("start_over_digit", COOK, 0, 0, 9, 1, 0);
        stop(); stop(); key(4'd0);
        chk("set_zero", SET, 0, 0, 0, 0, 0);
        press_start();
        chk("start_zero", IDLE, 0, 0, 0, 0, 0);

        key(4'd9); key(4'd0); press_start(); tick_();
        chk("0_90_tick", COOK, 0, 8, 9, 1, 0);
        @(negedge clk);
        reset_n  = 1'b0;
        sec_tick = 1'b1;
        @(posedge clk);
        #1;
        sec_tick = 1'b0;
        chk("reset_cook", IDLE, 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        key(4'd2); press_start(); tick_(); tick_();
        chk("expire_2", DONE, 0, 0, 0, 0, AL_ON);
        door_open = 1'b1;
        idle();
        chk("done_door_exit", IDLE, 0, 0, 0, 0, 0);
        door_open = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/microwave_timer_ctrl.md
MICROWAVE_TIMER_CTRL -- requirements
Module: microwave_timer_ctrl

Interface
REQ-001 Parameter: ALARM_TICKS, default 3, number of sec_tick pulses the alarm is held in DONE.
REQ-002 Parameter: QUICK_SECS_TENS, default 3, tens-of-seconds digit loaded by quick start (0:30).
REQ-003 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: reset_n  input  1  reset, synchronous, active-low.
REQ-005 Port: sec_tick  input  1  one-clk pulse, once per second.
REQ-006 Port: digit_valid  input  1  keypad digit strobe, one clk wide.
REQ-007 Port: digit  input  4  keypad BCD value.
REQ-008 Port: start  input  1  start key pulse.
REQ-009 Port: stop_clear  input  1  stop/clear key pulse.
REQ-010 Port: door_open  input  1  door switch level; 1 = open.
REQ-011 Port: min, sec_tens, sec_ones  output  4 each  BCD time, fed to the 7-segment decoder.
REQ-012 Port: mag_on  output  1  magnetron enable.
REQ-013 Port: alarm  output  1  done alarm.
REQ-014 Port: state_o  output  3  current state encoding, for debug and the bench.

Function
REQ-015 FSM states SHALL be IDLE, SET, COOK, PAUSE, DONE; all outputs registered, so there is 1-clk latency from input to output.
REQ-016 Input priority within one clk SHALL be stop_clear > door_open > start > sec_tick > digit_valid.
REQ-017 In IDLE or SET, a valid digit (value <= 9) SHALL shift in: min<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit, then state=SET; digits >9 SHALL be ignored.
REQ-018 Digits SHALL be ignored in COOK, PAUSE and DONE.
REQ-019 Start in SET with time != 0:00 and door closed SHALL go to COOK; with time 0:00 it SHALL go to IDLE.
REQ-020 Start in IDLE with door closed SHALL load 0:QUICK_SECS_TENS0 and go to COOK.
REQ-021 Start in PAUSE with door closed SHALL resume COOK with time unchanged.
REQ-022 Start with the door open SHALL be ignored in every state.
REQ-023 In COOK, each sec_tick SHALL decrement the time in BCD: sec_ones 0 wraps to 9 with a borrow; sec_tens 0 wraps to 5 with a borrow; min is decremented on borrow.
REQ-024 Entered sec_tens values 6-9 SHALL count down naturally (for example 0:90 -> 0:89).
REQ-025 A tick at 0:01 SHALL produce 0:00 and move to DONE in the same clk.
REQ-026 door_open in COOK SHALL go to PAUSE; a tick arriving in the same clk SHALL be dropped.
REQ-027 stop_clear in COOK SHALL go to PAUSE.
REQ-028 stop_clear in PAUSE, SET or DONE SHALL clear the time to 0:00 and go to IDLE.
REQ-029 mag_on SHALL be 1 only in COOK.
REQ-030 DONE SHALL hold 0:00 and exit as defined in REQ-034/REQ-035.

Reset
REQ-031 On reset_n=0 at a clk edge, the block SHALL go to IDLE with min=sec_tens=sec_ones=0, mag_on=0, alarm=0 and the alarm counter at 0.
REQ-032 Reset in mid-COOK SHALL drop mag_on on the next clk.
REQ-033 Reset SHALL take precedence over all other inputs.

Configuration
REQ-034 With DONE_ALARM_EN defined, DONE SHALL assert alarm, count ALARM_TICKS sec_ticks, then deassert alarm and go to IDLE; stop_clear or door_open SHALL end DONE early.
REQ-035 Without DONE_ALARM_EN, alarm SHALL be constant 0, DONE SHALL last exactly 1 clk before IDLE, and no alarm counter SHALL exist.

Structure
REQ-036 A shared package SHALL hold the state enum/encodings, the BCD digit type, and the quick-start and alarm default constants.
REQ-037 One sub-module, bcd_time_dec, SHALL be used: a combinational 3-digit BCD decrement with a zero flag.

Verification
REQ-038 Keys 1,3,0 then start -> time 1:30, mag_on=1; 90 ticks -> 0:00, DONE, mag_on=0.
REQ-039 Time 1:00, one tick -> 0:59; at 0:10, one tick -> 0:09.
REQ-040 COOK at 0:45, door_open with a simultaneous tick -> PAUSE at 0:45; door closed, then start -> COOK, next tick -> 0:44.
REQ-041 IDLE, start -> 0:30 COOK; stop_clear -> PAUSE; stop_clear again -> IDLE 0:00.
REQ-042 With DONE_ALARM_EN, expire -> alarm=1 for 3 ticks, then IDLE; without the macro, alarm stays 0 and DONE lasts 1 clk.
REQ-043 Digit 0xC entered -> ignored; reset_n=0 in COOK -> next clk IDLE, all outputs 0.
